// File: rtl/constants.sv
// Core-wide constants shared by every pipeline stage.
package constants;

    localparam logic [31:0] RESET_ADDRESS   = 32'h0000_0000;
    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

endpackage

// File: rtl/pipeline_status.sv
// Status codes exchanged between fetch and decode.
// forwards_t travels with each instruction; backwards_t is decode's request to fetch.
package pipeline_status;

    typedef enum logic [1:0] {
        VALID            = 2'd0,
        BUBBLE           = 2'd1,
        FETCH_FAULT      = 2'd2,
        FETCH_MISALIGNED = 2'd3
    } forwards_t;

    typedef enum logic [1:0] {
        READY = 2'd0,
        STALL = 2'd1,
        JUMP  = 2'd2
    } backwards_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a single-outstanding instruction bus and
// hands one registered instruction per cycle to decode, honouring stall and
// redirect requests coming back from decode.
module fetch_stage
    import pipeline_status::*;
    import constants::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        instr_cyc_out,
    output logic        instr_stb_out,
    output logic [31:0] instr_addr_out,
    input  logic        instr_ack_in,
    input  logic        instr_err_in,
    input  logic [31:0] instr_rdata_in,
    output logic [31:0] instruction_reg_out,
    output logic [31:0] program_counter_reg_out,
    output forwards_t   status_forwards_out,
    input  backwards_t  status_backwards_in,
    input  logic [31:0] jump_address_backwards_in
);

    // state     | meaning
    // S_FETCH   | bus cycle outstanding at r_pc
    // S_HOLD    | result (word, bus fault or misaligned target) buffered, bus idle
    // S_DISCARD | bus cycle outstanding at r_inflight_addr, result dropped, r_pc holds redirect
    // S_FAULT   | bus idle, waiting for a JUMP
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    state_t      w_redirect_state;

    // In S_HOLD r_pc is still the address of the buffered entry; it only
    // advances when that entry is handed to decode.
    logic [31:0] r_pc;
    logic [31:0] r_inflight_addr;
    logic [31:0] r_hold_instr;
    forwards_t   r_hold_kind;
    logic [31:0] r_instr;
    logic [31:0] r_out_pc;
    forwards_t   r_status;

    logic        w_jump;
    logic        w_stall;
    logic        w_bus_active;
    logic        w_done;
    logic        w_target_misaligned;
    logic        w_pc_misaligned;
    logic        w_cyc;
    logic [31:0] w_addr;

    assign w_jump              = (status_backwards_in == JUMP);
    assign w_stall             = (status_backwards_in == STALL);
    assign w_bus_active        = (r_state == S_FETCH) || (r_state == S_DISCARD);
    assign w_done              = w_bus_active && (instr_ack_in || instr_err_in);
    assign w_target_misaligned = (jump_address_backwards_in[1:0] != 2'b00);
    assign w_pc_misaligned     = (r_pc[1:0] != 2'b00);
    // A misaligned target never reaches the bus; it is parked in the hold
    // buffer so it is reported on the next non-stalled cycle.
    assign w_redirect_state    = w_target_misaligned ? S_HOLD : S_FETCH;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a JUMP outranks every other event.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_jump) begin
                    w_state_nxt = w_done ? w_redirect_state : S_DISCARD;
                end else if (w_done) begin
                    if (w_stall) begin
                        w_state_nxt = S_HOLD;
                    end else if (instr_err_in) begin
                        w_state_nxt = S_FAULT;
                    end
                end
            end
            S_HOLD: begin
                if (w_jump) begin
                    w_state_nxt = w_redirect_state;
                end else if (!w_stall) begin
                    w_state_nxt = (r_hold_kind == VALID) ? S_FETCH : S_FAULT;
                end
            end
            S_DISCARD: begin
                if (w_jump) begin
                    if (w_done) begin
                        w_state_nxt = w_redirect_state;
                    end
                end else if (w_done) begin
                    w_state_nxt = w_pc_misaligned ? S_HOLD : S_FETCH;
                end
            end
            S_FAULT: begin
                if (w_jump) begin
                    w_state_nxt = w_redirect_state;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Bus outputs; the cycle drops combinationally while reset is asserted.
    always_comb begin
        w_cyc  = 1'b0;
        w_addr = r_pc;
        case (r_state)
            S_FETCH:   w_cyc = 1'b1;
            S_DISCARD: begin
                w_cyc  = 1'b1;
                w_addr = r_inflight_addr;
            end
            default: ;
        endcase
    end

    assign instr_cyc_out  = w_cyc & ~rst;
    assign instr_stb_out  = w_cyc & ~rst;
    assign instr_addr_out = w_addr;

    // Datapath: pc, in-flight address, hold buffer and the decode-facing registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc            <= RESET_ADDRESS;
            r_inflight_addr <= RESET_ADDRESS;
            r_hold_instr    <= NOP_INSTRUCTION;
            r_hold_kind     <= VALID;
            r_instr         <= NOP_INSTRUCTION;
            r_out_pc        <= RESET_ADDRESS;
            r_status        <= BUBBLE;
        end else if (w_jump) begin
            r_status <= BUBBLE;
            r_pc     <= jump_address_backwards_in;
            if (r_state == S_FETCH) begin
                r_inflight_addr <= r_pc;
            end
            if (w_state_nxt == S_HOLD) begin
                r_hold_kind  <= FETCH_MISALIGNED;
                r_hold_instr <= NOP_INSTRUCTION;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_done && w_stall) begin
                        r_hold_kind  <= instr_ack_in ? VALID : FETCH_FAULT;
                        r_hold_instr <= instr_ack_in ? instr_rdata_in : NOP_INSTRUCTION;
                    end else if (w_done) begin
                        r_instr  <= instr_ack_in ? instr_rdata_in : NOP_INSTRUCTION;
                        r_out_pc <= r_pc;
                        r_status <= instr_ack_in ? VALID : FETCH_FAULT;
                        if (instr_ack_in) begin
                            r_pc <= r_pc + 32'd4;
                        end
                    end else if (!w_stall) begin
                        r_status <= BUBBLE;
                    end
                end
                S_HOLD: begin
                    if (!w_stall) begin
                        r_instr  <= r_hold_instr;
                        r_out_pc <= r_pc;
                        r_status <= r_hold_kind;
                        if (r_hold_kind == VALID) begin
                            r_pc <= r_pc + 32'd4;
                        end
                    end
                end
                S_DISCARD: begin
                    if (!w_stall) begin
                        r_status <= BUBBLE;
                    end
                    if (w_state_nxt == S_HOLD) begin
                        r_hold_kind  <= FETCH_MISALIGNED;
                        r_hold_instr <= NOP_INSTRUCTION;
                    end
                end
                S_FAULT: begin
                    if (!w_stall) begin
                        r_status <= BUBBLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instruction_reg_out     = r_instr;
    assign program_counter_reg_out = r_out_pc;
    assign status_forwards_out     = r_status;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// randomized decode/bus behaviour checked every cycle against a
// transaction-level model (outstanding request + one waiting result).
module tb_fetch_stage;
    import pipeline_status::*;
    import constants::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_cyc_out;
    logic        instr_stb_out;
    logic [31:0] instr_addr_out;
    logic        instr_ack_in;
    logic        instr_err_in;
    logic [31:0] instr_rdata_in;
    logic [31:0] instruction_reg_out;
    logic [31:0] program_counter_reg_out;
    forwards_t   status_forwards_out;
    backwards_t  status_backwards_in;
    logic [31:0] jump_address_backwards_in;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // model: expected decode-facing outputs
    forwards_t   m_st;
    logic [31:0] m_instr;
    logic [31:0] m_opc;
    // model: fetch bookkeeping
    logic [31:0] m_pc;
    logic        m_live;
    logic [31:0] m_req_addr;
    logic        m_drop;
    logic        m_buf_full;
    forwards_t   m_buf_kind;
    logic [31:0] m_buf_word;
    logic [31:0] m_buf_pc;
    logic        m_halted;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk                       (clk),
        .rst                       (rst),
        .instr_cyc_out             (instr_cyc_out),
        .instr_stb_out             (instr_stb_out),
        .instr_addr_out            (instr_addr_out),
        .instr_ack_in              (instr_ack_in),
        .instr_err_in              (instr_err_in),
        .instr_rdata_in            (instr_rdata_in),
        .instruction_reg_out       (instruction_reg_out),
        .program_counter_reg_out   (program_counter_reg_out),
        .status_forwards_out       (status_forwards_out),
        .status_backwards_in       (status_backwards_in),
        .jump_address_backwards_in (jump_address_backwards_in)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One edge of the reference behaviour, given the inputs seen at that edge.
    task automatic model_step(input logic r, input backwards_t st, input logic [31:0] ja,
                              input logic ack, input logic err, input logic [31:0] rd);
        logic done;
        if (r) begin
            m_pc       = RESET_ADDRESS;
            m_live     = 1'b0;
            m_drop     = 1'b0;
            m_buf_full = 1'b0;
            m_halted   = 1'b0;
            m_st       = BUBBLE;
            m_instr    = NOP_INSTRUCTION;
            m_opc      = RESET_ADDRESS;
        end else begin
            done = m_live && (ack || err);
            if (st == JUMP) begin
                m_st       = BUBBLE;
                m_pc       = ja;
                m_buf_full = 1'b0;
                m_halted   = 1'b0;
                if (done) m_live = 1'b0;
                else if (m_live) m_drop = 1'b1;
            end else begin
                if (done) begin
                    m_live = 1'b0;
                    if (!m_drop) begin
                        m_buf_full = 1'b1;
                        m_buf_kind = ack ? VALID : FETCH_FAULT;
                        m_buf_word = ack ? rd : NOP_INSTRUCTION;
                        m_buf_pc   = m_req_addr;
                    end
                end
                if (st == READY) begin
                    if (m_buf_full) begin
                        m_st       = m_buf_kind;
                        m_instr    = m_buf_word;
                        m_opc      = m_buf_pc;
                        m_buf_full = 1'b0;
                        if (m_buf_kind == VALID) m_pc = m_buf_pc + 32'd4;
                        else m_halted = 1'b1;
                    end else begin
                        m_st = BUBBLE;
                    end
                end
            end
        end
        // With the bus idle and nothing waiting, the next request goes out at pc.
        if (!m_live && !m_buf_full && !m_halted) begin
            if (m_pc[1:0] != 2'b00) begin
                m_buf_full = 1'b1;
                m_buf_kind = FETCH_MISALIGNED;
                m_buf_word = NOP_INSTRUCTION;
                m_buf_pc   = m_pc;
            end else begin
                m_live     = 1'b1;
                m_req_addr = m_pc;
                m_drop     = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    task automatic cyc_step(input logic r, input backwards_t st, input logic [31:0] ja,
                            input logic ack, input logic err, input logic [31:0] rd);
        rst                       = r;
        status_backwards_in       = st;
        jump_address_backwards_in = ja;
        instr_ack_in              = ack;
        instr_err_in              = err;
        instr_rdata_in            = rd;
        @(posedge clk);
        #1;
        model_step(r, st, ja, ack, err, rd);
    endtask

    // Zero-wait memory: acknowledge whenever a request is outstanding.
    task automatic zw(input backwards_t st, input logic [31:0] ja, input logic [31:0] rd);
        cyc_step(1'b0, st, ja, m_live, 1'b0, rd);
    endtask

    // Compare DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("bus_cyc", {31'd0, instr_cyc_out}, {31'd0, m_live && !rst});
            check("bus_stb", {31'd0, instr_stb_out}, {31'd0, m_live && !rst});
            if (m_live && !rst) check("bus_addr", instr_addr_out, m_req_addr);
            check("status", 32'(status_forwards_out), 32'(m_st));
            if (m_st != BUBBLE) begin
                check("instr", instruction_reg_out, m_instr);
                check("pc_out", program_counter_reg_out, m_opc);
            end
        end
    end

    initial begin
        logic        r;
        logic        a;
        logic        e;
        backwards_t  st;
        logic [31:0] ja;
        int          p;

        // reset and zero-wait streaming
        cyc_step(1'b1, READY, 32'd0, 1'b0, 1'b0, 32'd0);
        chk_en = 1'b1;
        cyc_step(1'b1, READY, 32'd0, 1'b0, 1'b0, 32'd0);
        check("rst_status", 32'(status_forwards_out), 32'(BUBBLE));
        check("rst_instr", instruction_reg_out, 32'h0000_0013);
        check("rst_pc", program_counter_reg_out, 32'h0000_0000);
        for (int i = 0; i < 3; i++) begin
            zw(READY, 32'd0, 32'h0000_0013);
            check("zw_pc", program_counter_reg_out, 32'(i * 4));
            check("zw_status", 32'(status_forwards_out), 32'(VALID));
            check("zw_instr", instruction_reg_out, 32'h0000_0013);
            check("zw_next_addr", instr_addr_out, 32'((i + 1) * 4));
        end

        // stall while the word for 0x100 arrives
        zw(JUMP, 32'h100, 32'd0);
        check("j100_addr", instr_addr_out, 32'h100);
        cyc_step(1'b0, STALL, 32'd0, 1'b1, 1'b0, 32'hCAFE_0100);
        check("hold_cyc", {31'd0, instr_cyc_out}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc_step(1'b0, STALL, 32'd0, 1'b0, 1'b0, 32'd0);
            check("hold_cyc2", {31'd0, instr_cyc_out}, 32'd0);
            check("hold_status", 32'(status_forwards_out), 32'(BUBBLE));
        end
        cyc_step(1'b0, READY, 32'd0, 1'b0, 1'b0, 32'd0);
        check("unhold_status", 32'(status_forwards_out), 32'(VALID));
        check("unhold_pc", program_counter_reg_out, 32'h100);
        check("unhold_instr", instruction_reg_out, 32'hCAFE_0100);
        check("unhold_next", instr_addr_out, 32'h104);

        // redirect while a slow fetch at 0x10 is outstanding
        zw(JUMP, 32'h10, 32'd0);
        cyc_step(1'b0, READY, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc_step(1'b0, JUMP, 32'h200, 1'b0, 1'b0, 32'd0);
        check("discard_cyc", {31'd0, instr_cyc_out}, 32'd1);
        check("discard_addr", instr_addr_out, 32'h10);
        cyc_step(1'b0, READY, 32'd0, 1'b1, 1'b0, 32'hBAD0_0010);
        check("discard_status", 32'(status_forwards_out), 32'(BUBBLE));
        check("discard_next", instr_addr_out, 32'h200);
        zw(READY, 32'd0, 32'h1234_5678);
        check("after_jump_pc", program_counter_reg_out, 32'h200);
        check("after_jump_st", 32'(status_forwards_out), 32'(VALID));

        // bus error at 0x40
        zw(JUMP, 32'h40, 32'd0);
        cyc_step(1'b0, READY, 32'd0, 1'b0, 1'b1, 32'd0);
        check("err_status", 32'(status_forwards_out), 32'(FETCH_FAULT));
        check("err_pc", program_counter_reg_out, 32'h40);
        check("err_instr", instruction_reg_out, 32'h0000_0013);
        for (int i = 0; i < 3; i++) begin
            cyc_step(1'b0, READY, 32'd0, 1'b0, 1'b0, 32'd0);
            check("fault_cyc", {31'd0, instr_cyc_out}, 32'd0);
            check("fault_status", 32'(status_forwards_out), 32'(BUBBLE));
        end
        cyc_step(1'b0, JUMP, 32'h80, 1'b0, 1'b0, 32'd0);
        check("resume_addr", instr_addr_out, 32'h80);
        zw(READY, 32'd0, 32'h0000_0080);
        check("resume_pc", program_counter_reg_out, 32'h80);

        // misaligned redirect
        zw(JUMP, 32'h202, 32'd0);
        check("mis_cyc", {31'd0, instr_cyc_out}, 32'd0);
        cyc_step(1'b0, READY, 32'd0, 1'b0, 1'b0, 32'd0);
        check("mis_status", 32'(status_forwards_out), 32'(FETCH_MISALIGNED));
        check("mis_pc", program_counter_reg_out, 32'h202);
        check("mis_cyc2", {31'd0, instr_cyc_out}, 32'd0);
        cyc_step(1'b0, JUMP, 32'h30, 1'b0, 1'b0, 32'd0);

        // reset in the middle of the fetch at 0x30, late ack during reset
        cyc_step(1'b0, READY, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc_step(1'b1, READY, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc_step(1'b1, READY, 32'd0, 1'b1, 1'b0, 32'hBAD0_0030);
        check("rst2_status", 32'(status_forwards_out), 32'(BUBBLE));
        check("rst2_addr", instr_addr_out, 32'h0000_0000);
        zw(READY, 32'd0, 32'h0000_0013);
        check("rst2_first_pc", program_counter_reg_out, 32'h0000_0000);
        check("rst2_first_st", 32'(status_forwards_out), 32'(VALID));

        // randomized decode behaviour and bus latency
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            p  = $urandom_range(0, 99);
            st = (p < 55) ? READY : ((p < 85) ? STALL : JUMP);
            ja = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0) ja[1:0] = 2'($urandom_range(1, 3));
            a = 1'b0;
            e = 1'b0;
            if (m_live && !r) begin
                p = $urandom_range(0, 99);
                if (p < 45) a = 1'b1;
                else if (p < 52) e = 1'b1;
            end
            cyc_step(r, st, ja, a, e, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 instr_cyc_out  out  1  instruction-bus cycle active.
REQ-004 instr_stb_out  out  1  instruction-bus strobe; always equal to instr_cyc_out.
REQ-005 instr_addr_out  out  32  word-aligned fetch address.
REQ-006 instr_ack_in  in  1  bus transfer complete; instr_rdata_in valid.
REQ-007 instr_err_in  in  1  bus transfer failed; mutually exclusive with ack.
REQ-008 instr_rdata_in  in  32  fetched instruction word.
REQ-009 instruction_reg_out  out  32  registered instruction to decode.
REQ-010 program_counter_reg_out  out  32  registered PC of instruction_reg_out.
REQ-011 status_forwards_out  out  pipeline_status::forwards_t  registered status to decode.
REQ-012 status_backwards_in  in  pipeline_status::backwards_t  READY / STALL / JUMP from decode.
REQ-013 jump_address_backwards_in  in  32  redirect target; valid when status_backwards_in == JUMP.

Function
REQ-014 States: FETCH (bus cycle outstanding at pc), HOLD (fetched word buffered, bus idle), DISCARD (bus cycle outstanding, result dropped, redirect pending), FAULT (bus idle, waiting for JUMP).
REQ-015 instr_cyc_out = 1 in FETCH and DISCARD, 0 in HOLD and FAULT; instr_addr_out = pc (internal register) in FETCH, the in-flight address in DISCARD.
REQ-016 Output registers (instruction, PC, status) update only when status_backwards_in != STALL; under STALL all three hold.
REQ-017 FETCH, ack, READY: instruction_reg_out <= rdata, program_counter_reg_out <= pc, status <= VALID, pc <= pc + 4 (mod 2^32), stay FETCH; next request issued the following cycle.
REQ-018 FETCH, ack, STALL: rdata and pc captured into hold buffer, state HOLD; outputs unchanged.
REQ-019 FETCH, no ack/err, READY: status <= BUBBLE.
REQ-020 HOLD, READY: buffered word/PC to outputs with VALID, pc <= pc + 4, state FETCH. HOLD, STALL: no change.
REQ-021 FETCH, err: on the first non-STALL cycle (immediately if READY) outputs take PC with status FETCH_FAULT, instruction NOP; state FAULT. Under STALL, the error is held in the buffer (state HOLD with fault flag).
REQ-022 FAULT: status <= BUBBLE on each non-STALL cycle; no bus activity until JUMP.
REQ-023 JUMP has priority over all other events in every state: status <= BUBBLE, pc <= jump_address, hold buffer invalidated.
REQ-024 JUMP while bus cycle outstanding and no ack/err that cycle -> DISCARD; jump target stored in pc; response discarded on ack/err; then FETCH at pc.
REQ-025 JUMP coinciding with ack/err, or in HOLD/FAULT/DISCARD-with-completion -> FETCH at the jump target next cycle; fetched word dropped.
REQ-026 Second JUMP in DISCARD overwrites pc; state stays DISCARD.
REQ-027 Jump target with addr[1:0] != 0: no bus request; outputs take target PC with status FETCH_MISALIGNED on the first non-STALL cycle; state FAULT.
REQ-028 A bus cycle, once started, is never abandoned: cyc and address stay stable until ack or err.
REQ-029 Throughput: one VALID per cycle with a zero-wait memory (ack the cycle after strobe), minimum fetch-to-output latency 1 edge after ack.

Reset
REQ-030 On rst: pc <= constants::RESET_ADDRESS, state FETCH, hold buffer invalid, instruction_reg_out <= instruction NOP encoding, program_counter_reg_out <= RESET_ADDRESS, status_forwards_out <= BUBBLE.
REQ-031 First request (addr = RESET_ADDRESS) is driven in the first cycle after rst deasserts.
REQ-032 rst mid bus cycle: cyc drops in the reset cycle; a late ack after reset is ignored when cyc = 0.

Structure
REQ-033 pipeline_status (VALID, BUBBLE, FETCH_FAULT, FETCH_MISALIGNED, READY, STALL, JUMP), constants::RESET_ADDRESS and the NOP encoding live in the shared packages; no local duplicates.
REQ-034 Single module, no sub-modules; state encoding is a local enum.

Verification
REQ-035 Reset release, zero-wait memory returning 0x00000013 -> addresses 0x…+0, +4, +8 on consecutive cycles, VALID every cycle with matching PCs.
REQ-036 STALL asserted 3 cycles while ack arrives for PC 0x100 -> outputs frozen, cyc low in HOLD; on READY output 0x100 VALID, next request 0x104.
REQ-037 JUMP to 0x200 while fetch at 0x10 waits 2 cycles for ack -> one BUBBLE, late word dropped, next address 0x200, first VALID PC 0x200.
REQ-038 err on fetch of 0x40 -> FETCH_FAULT with PC 0x40, then BUBBLEs and no bus activity until JUMP to 0x80 resumes fetching.
REQ-039 JUMP to 0x202 -> FETCH_MISALIGNED with PC 0x202, no bus cycle issued.
REQ-040 rst asserted mid-cycle at PC 0x30 with ack one cycle later -> ack ignored, first post-reset address RESET_ADDRESS, status BUBBLE.
